// File: rtl/sample_mixer.sv
// Per-frame playback mixer: on each lrclk rising edge it sums the live sample with one sample per enabled track.
// Optional build macro SAMPLE_MIXER_SAT_EN selects saturating output instead of wrap-around.
module sample_mixer #(
  parameter int NTRACKS     = 2,
  parameter int ACK_TIMEOUT = 255,
  localparam int TW         = (NTRACKS > 1) ? $clog2(NTRACKS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lrclk,
  input  logic [15:0]        live_sig,
  input  logic               live_en,
  input  logic [NTRACKS-1:0] tracks_playing,
  output logic               rd_req,
  output logic [TW-1:0]      rd_track,
  input  logic               rd_ack,
  input  logic [15:0]        rd_data,
  output logic [15:0]        mix_out,
  output logic               mix_valid,
  output logic               clip,
  output logic               overrun
);

  // Accumulator keeps enough headroom for live plus every track at full scale.
  localparam int AW = (NTRACKS > 2) ? (16 + $clog2(NTRACKS + 1) + 1) : 18;
  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic signed [AW-1:0] SAT_HI = {{(AW-16){1'b0}}, 16'h7FFF};
  localparam logic signed [AW-1:0] SAT_LO = {{(AW-16){1'b1}}, 16'h8000};
  localparam logic [CW-1:0]        WAIT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    REQ   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_r;
  logic                  lrclk_meta_r;
  logic                  lrclk_sync_r;
  logic                  lrclk_prev_r;
  logic                  frame_tick_r;
  logic [NTRACKS-1:0]    en_q_r;
  logic [TW-1:0]         rd_track_r;
  logic                  rd_req_r;
  logic signed [AW-1:0]  acc_r;
  logic [CW-1:0]         wait_r;
  logic [15:0]           mix_out_r;
  logic                  mix_valid_r;
  logic                  clip_r;
  logic                  overrun_r;

  logic [TW:0]           first_s;
  logic [TW:0]           next_s;
  logic                  timeout_s;
  logic                  over_s;
  logic                  under_s;
  logic [15:0]           mix_next_s;
  logic signed [AW-1:0]  live_ext_s;
  logic signed [AW-1:0]  data_ext_s;

  // Lowest set bit of en at or above index from; MSB of the result flags "found".
  function automatic logic [TW:0] find_from(input logic [NTRACKS-1:0] en, input int from);
    logic [TW:0] res;
    res = {(TW+1){1'b0}};
    for (int i = NTRACKS - 1; i >= 0; i--) begin
      if (en[i] && (i >= from)) begin
        res = {1'b1, TW'(i)};
      end
    end
    return res;
  endfunction

  // Two-flop synchronizer for the asynchronous word-select line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lrclk_meta_r <= 1'b0;
      lrclk_sync_r <= 1'b0;
    end else begin
      lrclk_meta_r <= lrclk;
      lrclk_sync_r <= lrclk_meta_r;
    end
  end

  // Registered rising-edge detector producing the one-cycle frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lrclk_prev_r <= 1'b0;
      frame_tick_r <= 1'b0;
    end else begin
      lrclk_prev_r <= lrclk_sync_r;
      frame_tick_r <= lrclk_sync_r & ~lrclk_prev_r;
    end
  end

  // Track selection, sign extension and timeout detection.
  always_comb begin
    first_s    = find_from(tracks_playing, 0);
    next_s     = find_from(en_q_r, int'(rd_track_r) + 1);
    timeout_s  = (wait_r == WAIT_LAST);
    live_ext_s = {{(AW-16){live_sig[15]}}, live_sig};
    data_ext_s = {{(AW-16){rd_data[15]}}, rd_data};
    over_s     = (acc_r > SAT_HI);
    under_s    = (acc_r < SAT_LO);
  end

`ifdef SAMPLE_MIXER_SAT_EN
  // Clamp the accumulator to the signed 16-bit range.
  always_comb begin
    mix_next_s = acc_r[15:0];
    if (over_s) begin
      mix_next_s = 16'h7FFF;
    end else if (under_s) begin
      mix_next_s = 16'h8000;
    end else begin
      mix_next_s = acc_r[15:0];
    end
  end
`else
  // Wrap-around output: keep the low 16 bits of the accumulator.
  always_comb begin
    mix_next_s = 16'h0000;
    mix_next_s = acc_r[15:0];
  end
`endif

  // Frame sequencer: latch enables, fetch each enabled track, then publish the mix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      en_q_r      <= {NTRACKS{1'b0}};
      rd_track_r  <= {TW{1'b0}};
      rd_req_r    <= 1'b0;
      acc_r       <= {AW{1'b0}};
      wait_r      <= {CW{1'b0}};
      mix_out_r   <= 16'h0000;
      mix_valid_r <= 1'b0;
      clip_r      <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      mix_valid_r <= 1'b0;
      // A frame edge while busy is dropped but remembered.
      if (frame_tick_r && (state_r != IDLE)) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
      case (state_r)
        IDLE: begin
          if (frame_tick_r) begin
            state_r <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          en_q_r <= tracks_playing;
          acc_r  <= live_en ? live_ext_s : {AW{1'b0}};
          wait_r <= {CW{1'b0}};
          if (first_s[TW]) begin
            rd_track_r <= first_s[TW-1:0];
            rd_req_r   <= 1'b1;
            state_r    <= REQ;
          end else begin
            state_r    <= DONE;
          end
        end
        REQ: begin
          if (rd_ack || timeout_s) begin
            // An ack on the last allowed cycle still counts as data.
            if (rd_ack) begin
              acc_r <= acc_r + data_ext_s;
            end else begin
              overrun_r <= 1'b1;
            end
            wait_r <= {CW{1'b0}};
            if (next_s[TW]) begin
              rd_track_r <= next_s[TW-1:0];
            end else begin
              rd_req_r <= 1'b0;
              state_r  <= DONE;
            end
          end else begin
            wait_r <= wait_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          mix_out_r   <= mix_next_s;
          clip_r      <= over_s | under_s;
          mix_valid_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          rd_req_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign rd_req    = rd_req_r;
  assign rd_track  = rd_track_r;
  assign mix_out   = mix_out_r;
  assign mix_valid = mix_valid_r;
  assign clip      = clip_r;
  assign overrun   = overrun_r;

endmodule
